// File: rtl/multi_clock_divider.sv
// multi_clock_divider: independent programmable clock divider channels
// driven from one system clock. Each channel has a pending/active divisor
// pair so a new divisor only takes effect at a period boundary, plus a
// global sync that restarts every running channel at count 0.
module multi_clock_divider #(
  parameter int          CHANNELS  = 4,
  parameter int          DIV_W     = 32,
  parameter int unsigned RESET_DIV = 2
) (
  input  logic                      clock_in,
  input  logic                      reset,
  input  logic [CHANNELS*DIV_W-1:0] divisor,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS-1:0]       enable,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       clock_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pending
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic [DIV_W-1:0] div_pend;
    logic             pend_valid;
    logic             active;
    logic             clk_q;
    logic             tick_q;

    logic [DIV_W-1:0] slice;
    logic [DIV_W-1:0] cnt_nxt;
    logic [DIV_W-1:0] div_nxt;
    logic             running;
    logic             wrap;
    logic             restart;
    logic             apply;
    logic             running_nxt;

    assign slice = divisor[i*DIV_W +: DIV_W];

    // A divisor of 0 or 1 is a stop condition even with enable high.
    assign running = enable[i] && (div_act >= DIV_W'(2));
    assign wrap    = (cnt == div_act - DIV_W'(1));

    // 'active' remembers whether the outputs were running after the last
    // edge; a channel that was idle restarts at count 0 so its first output
    // cycle is the high phase with a tick.
    assign restart = wrap || sync || !active;

    // The pending divisor is taken at any boundary, including every stopped
    // edge so a stopped channel can be started by loading a valid divisor.
    assign apply   = pend_valid && (!running || restart);
    assign div_nxt = apply ? div_pend : div_act;
    assign cnt_nxt = (!running || restart) ? '0 : cnt + DIV_W'(1);

    assign running_nxt = enable[i] && (div_nxt >= DIV_W'(2));

    // Per-channel counter, divisor pair and registered outputs.
    always_ff @(posedge clock_in or negedge reset) begin
      if (!reset) begin
        cnt        <= '0;
        div_act    <= DIV_W'(RESET_DIV);
        div_pend   <= '0;
        pend_valid <= 1'b0;
        active     <= 1'b0;
        clk_q      <= 1'b0;
        tick_q     <= 1'b0;
      end else begin
        cnt     <= cnt_nxt;
        div_act <= div_nxt;
        active  <= running_nxt;
        clk_q   <= running_nxt && (cnt_nxt < (div_nxt >> 1));
        tick_q  <= running_nxt && (cnt_nxt == '0);
        // A load on a boundary edge queues behind the value applied now.
        if (load[i]) begin
          div_pend   <= slice;
          pend_valid <= 1'b1;
        end else if (apply) begin
          pend_valid <= 1'b0;
        end
      end
    end

    assign clock_out[i] = clk_q;
    assign tick[i]      = tick_q;
    assign pending[i]   = pend_valid;
  end

endmodule

// File: tb/tb_multi_clock_divider.sv
// tb_multi_clock_divider: directed and randomized stimulus for the
// multi-channel clock divider, checked every cycle against a behavioural
// model that tracks each channel's position within its current period.
module tb_multi_clock_divider;

  localparam int CH = 4;
  localparam int W  = 32;

  logic            clock_in = 1'b0;
  logic            reset;
  logic [CH*W-1:0] divisor;
  logic [CH-1:0]   load;
  logic [CH-1:0]   enable;
  logic            sync;
  logic [CH-1:0]   clock_out;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   pending;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: active divisor, pending divisor and its flag, and the
  // position inside the current period (-1 while the channel is idle).
  longint m_d  [CH];
  longint m_p  [CH];
  longint m_ph [CH];
  bit     m_pv [CH];

  multi_clock_divider #(.CHANNELS(CH), .DIV_W(W), .RESET_DIV(2)) dut (
    .clock_in  (clock_in),
    .reset     (reset),
    .divisor   (divisor),
    .load      (load),
    .enable    (enable),
    .sync      (sync),
    .clock_out (clock_out),
    .tick      (tick),
    .pending   (pending)
  );

  // Free-running system clock.
  always #5 clock_in = ~clock_in;

  task automatic check_output(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_d[c]  = 2;
      m_p[c]  = 0;
      m_pv[c] = 1'b0;
      m_ph[c] = -1;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      bit run;
      bit boundary;
      run      = enable[c] && (m_d[c] >= 2);
      boundary = !run || (m_ph[c] < 0) || (m_ph[c] == m_d[c] - 1) || sync;
      if (boundary && m_pv[c]) begin
        m_d[c]  = m_p[c];
        m_pv[c] = 1'b0;
      end
      if (load[c]) begin
        m_p[c]  = longint'(divisor[c*W +: W]);
        m_pv[c] = 1'b1;
      end
      if (enable[c] && (m_d[c] >= 2))
        m_ph[c] = boundary ? 0 : m_ph[c] + 1;
      else
        m_ph[c] = -1;
    end
  endtask

  task automatic compare_all();
    logic [CH-1:0] e_co;
    logic [CH-1:0] e_tk;
    logic [CH-1:0] e_pd;
    for (int c = 0; c < CH; c++) begin
      e_co[c] = (m_ph[c] >= 0) && (m_ph[c] < m_d[c] / 2);
      e_tk[c] = (m_ph[c] == 0);
      e_pd[c] = m_pv[c];
    end
    check_output("clock_out", longint'(clock_out), longint'(e_co));
    check_output("tick",      longint'(tick),      longint'(e_tk));
    check_output("pending",   longint'(pending),   longint'(e_pd));
  endtask

  task automatic set_div(input int c, input longint val);
    divisor[c*W +: W] = W'(val);
  endtask

  // Inputs are driven at the falling edge, sampled by the DUT and the model
  // at the rising edge, and outputs are compared at the next falling edge.
  task automatic apply_stimulus(input logic [CH-1:0] en, input logic [CH-1:0] ld, input bit syn);
    enable = en;
    load   = ld;
    sync   = syn;
    @(posedge clock_in);
    model_step();
    @(negedge clock_in);
    compare_all();
    load = '0;
    sync = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(enable, '0, 1'b0);
  endtask

  initial begin
    reset   = 1'b0;
    divisor = '0;
    load    = '0;
    enable  = '0;
    sync    = 1'b0;
    model_reset();

    #12;
    compare_all();
    @(negedge clock_in);
    reset = 1'b1;

    // ch0 at the reset divisor of 2.
    apply_stimulus(4'b0001, '0, 1'b0);
    idle(9);

    // ch1 long period, ch2 divide-by-5, running independently.
    set_div(1, 956);
    set_div(2, 5);
    apply_stimulus(4'b0111, 4'b0110, 1'b0);
    idle(2000);

    // ch0 to 4, then a reload to 6 mid-period.
    set_div(0, 4);
    apply_stimulus(enable, 4'b0001, 1'b0);
    idle(6);
    set_div(0, 6);
    apply_stimulus(enable, 4'b0001, 1'b0);
    idle(20);

    // ch0 at 4 and ch1 at 7 out of phase, then a sync pulse.
    set_div(0, 4);
    set_div(1, 7);
    apply_stimulus(enable, 4'b0011, 1'b0);
    idle(13);
    apply_stimulus(enable, '0, 1'b1);
    idle(15);

    // Stop ch2 with divisors 1 and 0, then restart it with 3.
    set_div(2, 1);
    apply_stimulus(enable, 4'b0100, 1'b0);
    idle(10);
    set_div(2, 0);
    apply_stimulus(enable, 4'b0100, 1'b0);
    idle(10);
    set_div(2, 3);
    apply_stimulus(enable, 4'b0100, 1'b0);
    idle(12);

    // Largest divisor on ch3.
    set_div(3, 64'h0000_0000_FFFF_FFFF);
    apply_stimulus(4'b1111, 4'b1000, 1'b0);
    idle(40);

    // Randomized loads, enable toggles and sync pulses.
    for (int n = 0; n < 3000; n++) begin
      logic [CH-1:0] en;
      logic [CH-1:0] ld;
      en = enable;
      ld = '0;
      if ($urandom_range(0, 63) == 0) en[$urandom_range(0, CH-1)] ^= 1'b1;
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 31) == 0) begin
          ld[c] = 1'b1;
          set_div(c, longint'($urandom_range(0, 12)));
        end
      end
      apply_stimulus(en, ld, ($urandom_range(0, 59) == 0));
    end

    // Asynchronous reset mid-operation with a load pending on ch0.
    set_div(0, 8);
    apply_stimulus(4'b0001, '0, 1'b0);
    idle(3);
    set_div(0, 9);
    apply_stimulus(4'b0001, 4'b0001, 1'b0);
    @(posedge clock_in);
    #2;
    reset = 1'b0;
    #1;
    check_output("async_clock_out", longint'(clock_out), 0);
    check_output("async_tick",      longint'(tick),      0);
    check_output("async_pending",   longint'(pending),   0);
    model_reset();
    @(negedge clock_in);
    compare_all();
    reset = 1'b1;
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
